// File: rtl/seq_alu_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_alu_if
//  Description : Handshake and operand/result bundle between the issue stage
//                and the sequential ALU. master = issuing side, slave = ALU.
//  Revision    : 1.0  initial release
// ============================================================================
interface seq_alu_if #(
    parameter int WIDTH = 32
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       alu_operation;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] alu_c;
    logic             zero;
    logic             less_than;
    logic             signed_less_than;
    logic             busy;

    modport master (
        output flush, in_valid, alu_operation, alu_a, alu_b, out_ready,
        input  in_ready, out_valid, alu_c, zero, less_than, signed_less_than, busy
    );

    modport slave (
        input  flush, in_valid, alu_operation, alu_a, alu_b, out_ready,
        output in_ready, out_valid, alu_c, zero, less_than, signed_less_than, busy
    );
endinterface
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
//  Module      : seq_alu
//  Description : Handshaked ALU with registered result. Base integer ops take
//                one cycle; with SEQ_ALU_MULDIV_EN defined, RV32M-style
//                multiply/divide/remainder run one bit per cycle.
//                Macro SEQ_ALU_MULDIV_EN enables the multiply/divide datapath.
//  Revision    : 1.0  initial release
// ============================================================================
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  wire       clk,
    input  wire       rst,
    seq_alu_if.slave  bus
);
    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int CNT_W   = $clog2(WIDTH);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_busy = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    localparam logic [4:0] c_op_add  = 5'b00000;
    localparam logic [4:0] c_op_sub  = 5'b00001;
    localparam logic [4:0] c_op_and  = 5'b00010;
    localparam logic [4:0] c_op_or   = 5'b00011;
    localparam logic [4:0] c_op_xor  = 5'b00100;
    localparam logic [4:0] c_op_slt  = 5'b00101;
    localparam logic [4:0] c_op_srl  = 5'b00110;
    localparam logic [4:0] c_op_sra  = 5'b00111;
    localparam logic [4:0] c_op_sll  = 5'b01000;
    localparam logic [4:0] c_op_sltu = 5'b01001;

    logic [1:0]       r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;
    logic [WIDTH-1:0] r_alu_c;
    logic             r_zero;
    logic             r_lt;
    logic             r_slt;

    logic               w_accept;
    logic               w_is_mop;
    logic               w_m_last;
    logic [WIDTH-1:0]   w_m_result;
    logic [WIDTH-1:0]   w_base_c;
    logic [SHAMT_W-1:0] w_shamt;
    logic               w_zero;
    logic               w_lt;
    logic               w_slt;

    assign w_accept = r_in_ready & bus.in_valid & ~bus.flush;
    assign w_shamt  = bus.alu_b[SHAMT_W-1:0];
    assign w_zero   = (bus.alu_a == bus.alu_b);
    assign w_lt     = (bus.alu_a < bus.alu_b);
    assign w_slt    = ($signed(bus.alu_a) < $signed(bus.alu_b));

    assign bus.in_ready         = r_in_ready;
    assign bus.out_valid        = r_out_valid;
    assign bus.busy             = r_busy;
    assign bus.alu_c            = r_alu_c;
    assign bus.zero             = r_zero;
    assign bus.less_than        = r_lt;
    assign bus.signed_less_than = r_slt;

    // Single-cycle result of the base ops, sampled at accept time
    always_comb begin
        w_base_c = '0;
        case (bus.alu_operation)
            c_op_add:  w_base_c = bus.alu_a + bus.alu_b;
            c_op_sub:  w_base_c = bus.alu_a - bus.alu_b;
            c_op_and:  w_base_c = bus.alu_a & bus.alu_b;
            c_op_or:   w_base_c = bus.alu_a | bus.alu_b;
            c_op_xor:  w_base_c = bus.alu_a ^ bus.alu_b;
            c_op_slt:  w_base_c = {{(WIDTH-1){1'b0}}, w_slt};
            c_op_srl:  w_base_c = bus.alu_a >> w_shamt;
            c_op_sra:  w_base_c = $unsigned($signed(bus.alu_a) >>> w_shamt);
            c_op_sll:  w_base_c = bus.alu_a << w_shamt;
            c_op_sltu: w_base_c = {{(WIDTH-1){1'b0}}, w_lt};
            default:   w_base_c = '0;
        endcase
`ifdef SEQ_ALU_MULDIV_EN
        // Codes 11xxx alias ADD when the M extension is present
        if (bus.alu_operation[4] & bus.alu_operation[3])
            w_base_c = bus.alu_a + bus.alu_b;
`endif
    end

`ifdef SEQ_ALU_MULDIV_EN
    logic [2:0]         r_mop;
    logic               r_neg;
    logic               r_dz;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [2*WIDTH-1:0] r_prod;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [WIDTH-1:0]   r_divisor;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_rem;

    logic               w_is_div;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [2*WIDTH-1:0] w_prod_nxt;
    logic [2*WIDTH-1:0] w_prod_fin;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_rem_sub;
    logic [WIDTH-1:0]   w_rem_nxt;
    logic [WIDTH-1:0]   w_quo_nxt;
    logic [WIDTH-1:0]   w_rem_fin;
    logic [WIDTH-1:0]   w_quo_fin;

    assign w_is_mop = bus.alu_operation[4] & ~bus.alu_operation[3];
    assign w_is_div = bus.alu_operation[2];
    // Divides: signed unless the U variant (bit0). Multiplies: MULHU is the
    // only unsigned A; MULHSU and MULHU have unsigned B.
    assign w_a_neg  = bus.alu_a[WIDTH-1] &
                      (w_is_div ? ~bus.alu_operation[0] : (bus.alu_operation[1:0] != 2'b11));
    assign w_b_neg  = bus.alu_b[WIDTH-1] &
                      (w_is_div ? ~bus.alu_operation[0] : ~bus.alu_operation[1]);
    assign w_mag_a  = w_a_neg ? -bus.alu_a : bus.alu_a;
    assign w_mag_b  = w_b_neg ? -bus.alu_b : bus.alu_b;

    // One shift-add step and one restoring-divide step per BUSY cycle
    assign w_prod_nxt = r_prod + (r_mplier[0] ? r_mcand : '0);
    assign w_rem_sh   = {r_rem, r_quo[WIDTH-1]};
    assign w_rem_sub  = w_rem_sh - {1'b0, r_divisor};
    assign w_rem_nxt  = w_rem_sub[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_rem_sub[WIDTH-1:0];
    assign w_quo_nxt  = {r_quo[WIDTH-2:0], ~w_rem_sub[WIDTH]};

    assign w_prod_fin = r_neg ? -w_prod_nxt : w_prod_nxt;
    assign w_quo_fin  = r_neg ? -w_quo_nxt  : w_quo_nxt;
    assign w_rem_fin  = r_neg ? -w_rem_nxt  : w_rem_nxt;
    assign w_m_last   = r_dz | (r_cnt == '0);

    // Final M-op result selection on the last iteration
    always_comb begin
        w_m_result = '0;
        if (!r_mop[2])
            w_m_result = (r_mop[1:0] == 2'b00) ? w_prod_fin[WIDTH-1:0]
                                               : w_prod_fin[2*WIDTH-1:WIDTH];
        else if (r_dz)
            w_m_result = r_mop[1] ? r_a : '1;
        else
            w_m_result = r_mop[1] ? w_rem_fin : w_quo_fin;
    end

    // Load magnitudes on accept, then iterate while BUSY
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mop <= '0;
            r_neg <= 1'b0;
            r_dz  <= 1'b0;
            r_cnt <= '0;
        end else if (w_accept && w_is_mop) begin
            r_mop     <= bus.alu_operation[2:0];
            r_neg     <= (w_is_div && bus.alu_operation[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
            r_dz      <= w_is_div && (bus.alu_b == '0);
            r_cnt     <= CNT_W'(WIDTH - 1);
            r_a       <= bus.alu_a;
            r_prod    <= '0;
            r_mcand   <= {{WIDTH{1'b0}}, w_mag_a};
            r_mplier  <= w_mag_b;
            r_divisor <= w_mag_b;
            r_quo     <= w_mag_a;
            r_rem     <= '0;
        end else if (r_state == c_st_busy) begin
            r_cnt    <= r_cnt - CNT_W'(1);
            r_prod   <= w_prod_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_quo    <= w_quo_nxt;
            r_rem    <= w_rem_nxt;
        end
    end
`else
    assign w_is_mop   = 1'b0;
    assign w_m_last   = 1'b1;
    assign w_m_result = '0;
`endif

    // Control FSM with registered handshake, result and flag outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_alu_c     <= '0;
            r_zero      <= 1'b0;
            r_lt        <= 1'b0;
            r_slt       <= 1'b0;
        end else if (bus.flush) begin
            r_state     <= c_st_idle;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_in_ready <= 1'b0;
                        r_zero     <= w_zero;
                        r_lt       <= w_lt;
                        r_slt      <= w_slt;
                        if (w_is_mop) begin
                            r_state <= c_st_busy;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state     <= c_st_done;
                            r_out_valid <= 1'b1;
                            r_alu_c     <= w_base_c;
                        end
                    end
                end
                c_st_busy: begin
                    if (w_m_last) begin
                        r_state     <= c_st_done;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_alu_c     <= w_m_result;
                    end
                end
                c_st_done: begin
                    if (bus.out_ready) begin
                        r_state     <= c_st_idle;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= c_st_idle;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_alu
//  Description : Directed self-checking bench for seq_alu. Expected values
//                for M ops depend on SEQ_ALU_MULDIV_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seq_alu;
    localparam int WIDTH = 32;

`ifdef SEQ_ALU_MULDIV_EN
    localparam int c_mlat = WIDTH + 1;
    localparam int c_dzlat = 2;
`else
    localparam int c_mlat = 1;
    localparam int c_dzlat = 1;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    seq_alu_if #(.WIDTH(WIDTH)) bus ();
    seq_alu #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [WIDTH-1:0] got,
                             input logic [WIDTH-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [4:0] op, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b);
        int guard = 0;
        while (!bus.in_ready && guard < 100) begin
            step();
            guard++;
        end
        bus.alu_operation = op;
        bus.alu_a         = a;
        bus.alu_b         = b;
        bus.in_valid      = 1'b1;
        step();
        bus.in_valid      = 1'b0;
    endtask

    task automatic vec(input string tag, input logic [4:0] op,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] exp_c, input logic [2:0] exp_flags,
                       input int exp_lat);
        int lat;
        accept(op, a, b);
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            step();
            lat++;
        end
        check_val({tag, ".c"}, bus.alu_c, exp_c);
        check_val({tag, ".flags"},
                  {29'd0, bus.zero, bus.less_than, bus.signed_less_than},
                  {29'd0, exp_flags});
        check_val({tag, ".lat"}, WIDTH'(lat), WIDTH'(exp_lat));
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, ".in_ready"},  {31'd0, bus.in_ready}, 32'd1);
        check_val({tag, ".out_valid"}, {31'd0, bus.out_valid}, 32'd0);
        check_val({tag, ".busy"},      {31'd0, bus.busy}, 32'd0);
        check_val({tag, ".alu_c"},     bus.alu_c, 32'd0);
        check_val({tag, ".flags"},
                  {29'd0, bus.zero, bus.less_than, bus.signed_less_than}, 32'd0);
    endtask

    initial begin
        int hits;
        rst               = 1'b1;
        bus.flush         = 1'b0;
        bus.in_valid      = 1'b0;
        bus.out_ready     = 1'b0;
        bus.alu_operation = 5'd0;
        bus.alu_a         = '0;
        bus.alu_b         = '0;
        step();
        step();
        rst = 1'b0;
        check_reset_state("reset");

        // Base ops: tag, op, a, b, expected c, {zero, lt, slt}, latency
        vec("add_wrap", 5'b00000, 32'hFFFF_FFFF, 32'h1, 32'h0, 3'b001, 1);
        vec("sub",      5'b00001, 32'd5, 32'd7, 32'hFFFF_FFFE, 3'b011, 1);
        vec("and",      5'b00010, 32'hF0F0_A5A5, 32'h0FF0_FFFF, 32'h00F0_A5A5, 3'b001, 1);
        vec("or",       5'b00011, 32'hF0F0_A5A5, 32'h0FF0_FFFF, 32'hFFF0_FFFF, 3'b001, 1);
        vec("xor",      5'b00100, 32'hF0F0_A5A5, 32'h0FF0_FFFF, 32'hFF00_5A5A, 3'b001, 1);
        vec("slt",      5'b00101, 32'hFFFF_FFFE, 32'd3, 32'd1, 3'b001, 1);
        vec("sltu",     5'b01001, 32'hFFFF_FFFE, 32'd3, 32'd0, 3'b001, 1);
        vec("sra",      5'b00111, 32'h8000_0000, 32'h24, 32'hF800_0000, 3'b001, 1);
        vec("srl",      5'b00110, 32'h8000_0000, 32'h24, 32'h0800_0000, 3'b001, 1);
        vec("sll",      5'b01000, 32'h1, 32'h21, 32'h2, 3'b011, 1);
        vec("undef",    5'b01010, 32'd5, 32'd5, 32'd0, 3'b100, 1);
`ifdef SEQ_ALU_MULDIV_EN
        vec("alias_add", 5'b11000, 32'd2, 32'd3, 32'd5, 3'b011, 1);
        vec("mulh",   5'b10001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 3'b100, c_mlat);
        vec("mulhu",  5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 3'b100, c_mlat);
        vec("mul",    5'b10000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 3'b100, c_mlat);
        vec("mulhsu", 5'b10010, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 3'b001, c_mlat);
        vec("div_ovf", 5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 3'b011, c_mlat);
        vec("rem_ovf", 5'b10110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 3'b011, c_mlat);
        vec("div_neg", 5'b10100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 3'b001, c_mlat);
        vec("rem_neg", 5'b10110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 3'b001, c_mlat);
        vec("divu_dz", 5'b10101, 32'd7, 32'd0, 32'hFFFF_FFFF, 3'b000, c_dzlat);
        vec("remu_dz", 5'b10111, 32'd7, 32'd0, 32'd7, 3'b000, c_dzlat);
`else
        vec("alias_add", 5'b11000, 32'd2, 32'd3, 32'd0, 3'b011, 1);
        vec("mulh",    5'b10001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 3'b100, c_mlat);
        vec("mulhu",   5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 3'b100, c_mlat);
        vec("div_ovf", 5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 3'b011, c_mlat);
        vec("divu_dz", 5'b10101, 32'd7, 32'd0, 32'h0, 3'b000, c_dzlat);
`endif

        // Result held while the consumer stalls
        accept(5'b00000, 32'd3, 32'd4);
        for (int i = 0; i < 5; i++) begin
            check_val("hold.c", bus.alu_c, 32'd7);
            check_val("hold.flags",
                      {29'd0, bus.zero, bus.less_than, bus.signed_less_than}, 32'd3);
            check_val("hold.valid_ready", {30'd0, bus.out_valid, bus.in_ready}, 32'd2);
            step();
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check_val("release.valid_ready", {30'd0, bus.out_valid, bus.in_ready}, 32'd1);

        // flush in IDLE blocks the accept
        bus.flush         = 1'b1;
        bus.in_valid      = 1'b1;
        bus.alu_operation = 5'b00000;
        bus.alu_a         = 32'd1;
        bus.alu_b         = 32'd1;
        step();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check_val("idle_flush.valid_ready", {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
        step();
        check_val("idle_flush.later", {30'd0, bus.out_valid, bus.in_ready}, 32'd1);

        // flush mid-operation: DIV in BUSY (or DONE when M ops are absent)
        accept(5'b10100, 32'd100, 32'd7);
`ifdef SEQ_ALU_MULDIV_EN
        repeat (9) step();
        check_val("mid_flush.busy", {31'd0, bus.busy}, 32'd1);
`else
        check_val("mid_flush.done", {31'd0, bus.out_valid}, 32'd1);
`endif
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        check_val("mid_flush.state",
                  {29'd0, bus.out_valid, bus.busy, bus.in_ready}, 32'd1);
        hits = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid) hits++;
            step();
        end
        check_val("mid_flush.no_result", WIDTH'(hits), 32'd0);

        // rst mid-operation returns every output to its reset value
        accept(5'b10100, 32'd9, 32'd9);
`ifdef SEQ_ALU_MULDIV_EN
        repeat (9) step();
`endif
        check_val("mid_rst.zero_before", {31'd0, bus.zero}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_state("mid_rst");
        hits = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid) hits++;
            step();
        end
        check_val("mid_rst.no_result", WIDTH'(hits), 32'd0);

        // Unit still works after the abort
        vec("post_rst_add", 5'b00000, 32'd10, 32'd20, 32'd30, 3'b011, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, handshaked successor to the single-cycle combinational ALU.
- Executes the base integer ops with a registered result.
- Also executes RV32M-style multiply/divide/remainder iteratively, one bit per cycle.
- Sits between decode/operand-fetch and writeback; stalls upstream through in_ready and holds its result until writeback accepts it.

Parameters:
- WIDTH, 32, operand/result width in bits; legal range 8 to 64.
- SHAMT_W, $clog2(WIDTH), shift-amount bits taken from alu_b[SHAMT_W-1:0]; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- flush  input  1  abort the current operation; the result is discarded
- in_valid  input  1  operation and operands presented
- in_ready  output  1  unit can accept an operation
- alu_operation  input  5  op code (see Behaviour)
- alu_a  input  WIDTH  operand A / dividend / multiplicand
- alu_b  input  WIDTH  operand B / divisor / multiplier / shift amount
- out_valid  output  1  result and flags valid
- out_ready  input  1  consumer accepts the result
- alu_c  output  WIDTH  result
- zero  output  1  registered (alu_a == alu_b) of the accepted operation
- less_than  output  1  registered unsigned alu_a < alu_b
- signed_less_than  output  1  registered signed alu_a < alu_b
- busy  output  1  high in BUSY state

Behaviour:
- Clock and reset:
  - Single clock clk; reset rst is synchronous and active-high.
  - On rst: state=IDLE, in_ready=1, out_valid=0, busy=0, alu_c=0, zero=0, less_than=0, signed_less_than=0.
  - rst mid-operation abandons it with no result emitted.
- Op codes, base ops (bit4=0):
  - ADD 00000, SUB 00001, AND 00010, OR 00011, XOR 00100.
  - SLT 00101, SRL 00110, SRA 00111, SLL 01000, SLTU 01001.
  - SLT/SLTU write 1 or 0 zero-extended into alu_c.
  - Undefined base codes produce alu_c=0.
- Op codes, M ops (bit4=1):
  - MUL 10000, MULH 10001, MULHSU 10010, MULHU 10011.
  - DIV 10100, DIVU 10101, REM 10110, REMU 10111.
  - Codes 11000-11111 are treated as ADD.
- State machine: IDLE, BUSY, DONE.
  - in_ready = (state==IDLE). The op is accepted on a clock edge with in_valid & in_ready; operands and op are captured.
  - Base op: IDLE -> DONE. out_valid rises the cycle after accept (latency 1).
  - M op: IDLE -> BUSY. Exactly WIDTH iteration cycles, then BUSY -> DONE (out_valid latency WIDTH+1).
  - DONE: out_valid=1. All outputs are held stable until out_valid & out_ready, then -> IDLE. There is no back-to-back accept in the same cycle as result consumption.
- Flags are computed from the captured operands at accept time and presented with the result for every op.
- Multiply: shift-add over WIDTH cycles on magnitudes with sign correction, forming a 2*WIDTH product.
  - MUL returns the low half; MULH/MULHSU/MULHU return the high half.
  - Signedness: MULH signed x signed, MULHSU signed x unsigned, MULHU unsigned x unsigned.
- Divide: restoring divide over WIDTH cycles on magnitudes.
  - Quotient sign = sign(a) xor sign(b); remainder sign = sign(a).
- Division by zero: skips iteration, BUSY lasts 1 cycle.
  - DIV/DIVU return all-ones.
  - REM/REMU return alu_a.
- Signed overflow (most-negative / -1) follows the normal path:
  - DIV returns the most-negative value; REM returns 0.
- Shifts use alu_b[SHAMT_W-1:0] only.
- All arithmetic wraps modulo 2^WIDTH; no overflow flag.
- flush:
  - In BUSY or DONE: -> IDLE next cycle; out_valid=0 and busy=0 next cycle.
  - flush in IDLE with in_valid: the op is not accepted.
  - flush has priority over out_ready and completion.
- Simultaneous flush and rst: rst wins; identical result.

Optional Feature:
- Macro: SEQ_ALU_MULDIV_EN.
- Defined: M ops as above.
- Undefined:
  - No multiply/divide datapath is built.
  - Any op with bit4=1 completes as a base op with latency 1 and alu_c=0; BUSY is unreachable.
  - Flags remain valid.

Test Plan:
- WIDTH=32, op=ADD, a=0xFFFFFFFF, b=1 -> out_valid one cycle after accept, alu_c=0, zero=0, less_than=0, signed_less_than=1.
- op=SLT, a=0xFFFFFFFE, b=3 -> alu_c=1. op=SRA, a=0x80000000, b=0x24 -> alu_c=0xF8000000 (shift 4).
- op=MULH, a=0xFFFFFFFF, b=0xFFFFFFFF -> alu_c=0 after 33 cycles. MULHU same operands -> alu_c=0xFFFFFFFE. MUL -> alu_c=1.
- op=DIV, a=0x80000000, b=0xFFFFFFFF -> alu_c=0x80000000. REM -> 0. DIVU a=7, b=0 -> alu_c=0xFFFFFFFF after 2 cycles. REMU -> 7.
- DONE with out_ready=0 for 5 cycles -> alu_c and flags stable, in_ready=0; out_ready=1 -> IDLE, in_ready=1 next cycle.
- DIV accepted, flush at iteration 10 -> out_valid never asserted, in_ready=1 next cycle. Repeat with rst mid-BUSY -> all outputs at reset values.
